// File: rtl/csoc_test_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csoc_test_pkg
// Purpose  : Shared constants for the CSoC test-harness command sequencer:
//            command opcodes, reply bytes, FSM state encoding, pulse counter
//            width and a helper that maps a burst argument to a pulse count.
// Revision : 1.0  initial release
// ============================================================================
package csoc_test_pkg;

   // Pulse counter must hold 256, the count encoded by an argument of 0x00
   localparam int unsigned c_cnt_w = 9;

   // Host command opcodes (first byte)
   localparam logic [7:0] c_op_rst  = 8'h52;   // 'R' reset sequence
   localparam logic [7:0] c_op_clk  = 8'h43;   // 'C' clock burst + N
   localparam logic [7:0] c_op_mode = 8'h4D;   // 'M' test mode + B
   localparam logic [7:0] c_op_wr   = 8'h57;   // 'W' write to CSoC + B
   localparam logic [7:0] c_op_get  = 8'h47;   // 'G' read hold byte

   // Reply bytes
   localparam logic [7:0] c_rep_ok  = 8'h4B;   // 'K'
   localparam logic [7:0] c_rep_err = 8'h45;   // 'E'
   localparam logic [7:0] c_rep_tmo = 8'h54;   // 'T'

   // Sequencer FSM encoding
   localparam logic [2:0] c_st_idle    = 3'd0;
   localparam logic [2:0] c_st_arg     = 3'd1;
   localparam logic [2:0] c_st_exec    = 3'd2;
   localparam logic [2:0] c_st_tx_req  = 3'd3;
   localparam logic [2:0] c_st_tx_wait = 3'd4;

   // Argument N of a burst command: 0 stands for 256 pulses
   function automatic logic [c_cnt_w-1:0] burst_len(input logic [7:0] n);
      return (n == 8'd0) ? 9'd256 : {1'b0, n};
   endfunction

   // Opcodes that are followed by one argument byte
   function automatic logic is_two_byte(input logic [7:0] op);
      return (op == c_op_clk) || (op == c_op_mode) || (op == c_op_wr);
   endfunction

endpackage
`default_nettype wire

// File: rtl/csoc_test_ctrl_clk_burst.sv
`default_nettype none
// ============================================================================
// Module   : csoc_clk_burst
// Purpose  : Emits a counted burst of CSoC clock pulses. Each pulse is high
//            for half_period clk cycles, then low for half_period cycles. The
//            clock goes high on the edge that samples start, and done is
//            asserted for one cycle during the last low cycle of the burst,
//            so a burst of N pulses occupies exactly 2*half_period*N cycles.
// Ports    : clk, rst        - system clock, async active-high reset
//            start           - one-cycle request, loads count
//            count[8:0]      - number of pulses (1..256)
//            half_period[7:0]- csoc_clk half-period in clk cycles (>=1)
//            csoc_clk        - generated clock, idles low
//            done            - one-cycle end-of-burst indication
// Revision : 1.0  initial release
// ============================================================================
module csoc_clk_burst
   import csoc_test_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [c_cnt_w-1:0] count,
   input  logic [7:0]         half_period,
   output logic               csoc_clk,
   output logic               done
);

   logic               r_active;
   logic               r_clk;
   logic [c_cnt_w-1:0] r_cnt;     // pulses still owed a falling edge
   logic [7:0]         r_div;     // cycles left in the current phase, minus one

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active <= 1'b0;
         r_clk    <= 1'b0;
         r_cnt    <= '0;
         r_div    <= 8'd0;
      end else if (start) begin
         r_active <= 1'b1;
         r_clk    <= 1'b1;
         r_cnt    <= count;
         r_div    <= half_period - 8'd1;
      end else if (r_active) begin
         if (r_div != 8'd0) begin
            r_div <= r_div - 8'd1;
         end else if (r_clk) begin
            // falling edge: this pulse is now complete
            r_clk <= 1'b0;
            r_cnt <= r_cnt - 9'd1;
            r_div <= half_period - 8'd1;
         end else if (r_cnt == '0) begin
            r_active <= 1'b0;
         end else begin
            r_clk <= 1'b1;
            r_div <= half_period - 8'd1;
         end
      end
   end

   assign csoc_clk = r_clk;
   assign done     = r_active && !r_clk && (r_div == 8'd0) && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/csoc_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csoc_test_ctrl
// Purpose  : Host-command sequencer between the harness UART byte interface
//            and the CSoC pins. Decodes 1-2 byte commands (R, C+N, M+B, W+B,
//            G), drives reset sequences, clock bursts, scan/test mode and the
//            CSoC data port, and answers every command with one reply byte.
// Ports    : clk, rst                       - clock, async active-high reset
//            rx_data, new_rx_data           - received host byte + strobe
//            tx_data, new_tx_data, tx_busy  - reply byte handshake
//            csoc_clk, csoc_rstn            - CSoC clock / active-low reset
//            csoc_test_se, csoc_test_tm     - scan enable / test mode
//            csoc_uart_write, csoc_data_i   - byte captured from the CSoC
//            csoc_uart_read, csoc_data_o    - byte presented to the CSoC
//            busy                           - sequencer not in IDLE
// Config   : CSOC_CMD_TIMEOUT_EN - when defined, an argument byte that does
//            not arrive within TIMEOUT_CYCLES aborts the command with 'T'.
// Revision : 1.0  initial release
// ============================================================================
module csoc_test_ctrl
   import csoc_test_pkg::*;
#(
   parameter int unsigned CLK_DIV        = 4,
   parameter int unsigned RST_CYCLES     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       new_rx_data,
   output logic [7:0] tx_data,
   output logic       new_tx_data,
   input  logic       tx_busy,
   output logic       csoc_clk,
   output logic       csoc_rstn,
   output logic       csoc_test_se,
   output logic       csoc_test_tm,
   input  logic       csoc_uart_write,
   input  logic [7:0] csoc_data_i,
   output logic       csoc_uart_read,
   output logic [7:0] csoc_data_o,
   output logic       busy
);

   localparam logic [c_cnt_w-1:0] c_rst_count = c_cnt_w'(RST_CYCLES);
   localparam logic [7:0]         c_half      = 8'(CLK_DIV);

   logic [2:0]         r_state;
   logic [7:0]         r_op;
   logic [7:0]         r_arg;
   logic [7:0]         r_tx_data;
   logic [7:0]         r_hold;
   logic               r_hold_valid;
   logic               r_rstn;
   logic               r_se;
   logic               r_tm;
   logic [7:0]         r_data_o;
   logic               r_read_pend;
   logic               r_uart_read;

   logic               w_start;
   logic [c_cnt_w-1:0] w_count;
   logic               w_burst_done;
   logic               w_get_clear;
   logic               w_timeout;

   // Burst launch: 'R' starts straight from IDLE, 'C' once its argument lands.
   always_comb begin
      w_start = 1'b0;
      w_count = burst_len(rx_data);
      if ((r_state == c_st_idle) && new_rx_data && (rx_data == c_op_rst)) begin
         w_start = 1'b1;
         w_count = c_rst_count;
      end else if ((r_state == c_st_arg) && new_rx_data && (r_op == c_op_clk)) begin
         w_start = 1'b1;
      end
   end

   csoc_clk_burst u_burst (
      .clk         (clk),
      .rst         (rst),
      .start       (w_start),
      .count       (w_count),
      .half_period (c_half),
      .csoc_clk    (csoc_clk),
      .done        (w_burst_done)
   );

`ifdef CSOC_CMD_TIMEOUT_EN
   logic [31:0] r_to_cnt;

   // Counts cycles spent in ARG; restarts from zero on every ARG entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt <= 32'd0;
      end else if (r_state == c_st_arg) begin
         r_to_cnt <= r_to_cnt + 32'd1;
      end else begin
         r_to_cnt <= 32'd0;
      end
   end

   assign w_timeout = (r_state == c_st_arg) && !new_rx_data &&
                      (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = |TIMEOUT_CYCLES;
   assign w_timeout        = 1'b0;
`endif

   // Sequencer FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= c_st_idle;
         r_op        <= 8'h00;
         r_arg       <= 8'h00;
         r_tx_data   <= 8'h00;
         r_rstn      <= 1'b0;
         r_se        <= 1'b0;
         r_tm        <= 1'b0;
         r_data_o    <= 8'h00;
         r_read_pend <= 1'b0;
         r_uart_read <= 1'b0;
      end else begin
         // csoc_uart_read trails the csoc_data_o update by one cycle
         r_read_pend <= 1'b0;
         r_uart_read <= r_read_pend;

         case (r_state)
            c_st_idle: begin
               if (new_rx_data) begin
                  r_op <= rx_data;
                  if (is_two_byte(rx_data)) begin
                     r_state <= c_st_arg;
                  end else begin
                     r_state <= c_st_exec;
                     if (rx_data == c_op_rst) begin
                        r_rstn <= 1'b0;
                     end
                  end
               end
            end

            c_st_arg: begin
               if (new_rx_data) begin
                  r_arg   <= rx_data;
                  r_state <= c_st_exec;
               end else if (w_timeout) begin
                  r_tx_data <= c_rep_tmo;
                  r_state   <= c_st_tx_req;
               end
            end

            c_st_exec: begin
               case (r_op)
                  c_op_rst, c_op_clk: begin
                     if (w_burst_done) begin
                        if (r_op == c_op_rst) begin
                           r_rstn <= 1'b1;
                        end
                        r_tx_data <= c_rep_ok;
                        r_state   <= c_st_tx_req;
                     end
                  end
                  c_op_mode: begin
                     r_tm      <= r_arg[0];
                     r_se      <= r_arg[1];
                     r_tx_data <= c_rep_ok;
                     r_state   <= c_st_tx_req;
                  end
                  c_op_wr: begin
                     r_data_o    <= r_arg;
                     r_read_pend <= 1'b1;
                     r_tx_data   <= c_rep_ok;
                     r_state     <= c_st_tx_req;
                  end
                  c_op_get: begin
                     // Register value is the pre-capture byte if a capture
                     // happens in this very cycle.
                     r_tx_data <= r_hold;
                     r_state   <= c_st_tx_req;
                  end
                  default: begin
                     r_tx_data <= c_rep_err;
                     r_state   <= c_st_tx_req;
                  end
               endcase
            end

            c_st_tx_req: begin
               if (!tx_busy) begin
                  r_state <= c_st_tx_wait;
               end
            end

            c_st_tx_wait: begin
               r_state <= c_st_idle;
            end

            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign w_get_clear = (r_state == c_st_exec) && (r_op == c_op_get);

   // Hold register: a capture beats a same-cycle 'G' clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold       <= 8'h00;
         r_hold_valid <= 1'b0;
      end else if (csoc_uart_write) begin
         r_hold       <= csoc_data_i;
         r_hold_valid <= 1'b1;
      end else if (w_get_clear) begin
         r_hold_valid <= 1'b0;
      end
   end

   // Request is combinational so it fires in the first tx_busy=0 cycle;
   // TX_REQ is left on that same edge, keeping it a single-cycle pulse.
   assign new_tx_data    = (r_state == c_st_tx_req) && !tx_busy;
   assign tx_data        = r_tx_data;
   assign csoc_rstn      = r_rstn;
   assign csoc_test_se   = r_se;
   assign csoc_test_tm   = r_tm;
   assign csoc_uart_read = r_uart_read;
   assign csoc_data_o    = r_data_o;
   assign busy           = (r_state != c_st_idle);

endmodule
`default_nettype wire
